// File: rtl/tetris_move_scheduler.sv
// PS/2 make/break decoder, auto-repeat and command arbiter for Tetris moves.
// Optional: ARROW_KEYS_EN maps E0-prefixed arrow keys onto the A/D/S/W moves.
module tetris_move_scheduler #(
  parameter int CNT_W        = 26,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  input  logic       tick,
  input  logic       enable,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  output logic [3:0] held,
  output logic       gravity_miss
);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_BRK,
    RX_EXT,
    RX_EXTBRK
  } rx_t;

  typedef enum logic {
    A_IDLE,
    A_OFFER
  } arb_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LEFT = 3'd1;
  localparam logic [2:0] OP_RGHT = 3'd2;
  localparam logic [2:0] OP_DROP = 3'd3;
  localparam logic [2:0] OP_ROT  = 3'd4;
  localparam logic [2:0] OP_GRAV = 3'd5;

  localparam logic [7:0] B_BRK = 8'hF0;
  localparam logic [7:0] B_EXT = 8'hE0;

  localparam logic [CNT_W-1:0] C_DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] C_RAT = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  // key vectors are {rotate,down,right,left}
  function automatic logic [3:0] map_std(input logic [7:0] b);
    logic [3:0] k;
    case (b)
      8'h1C:   k = 4'b0001;
      8'h23:   k = 4'b0010;
      8'h1B:   k = 4'b0100;
      8'h1D:   k = 4'b1000;
      default: k = 4'b0000;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] map_ext(input logic [7:0] b);
    logic [3:0] k;
`ifdef ARROW_KEYS_EN
    case (b)
      8'h6B:   k = 4'b0001;
      8'h74:   k = 4'b0010;
      8'h72:   k = 4'b0100;
      8'h75:   k = 4'b1000;
      default: k = 4'b0000;
    endcase
`else
    k = (b == 8'h00) ? 4'b0000 : 4'b0000;
`endif
    return k;
  endfunction

  rx_t             rx_q, rx_nxt;
  arb_t            a_q, a_nxt;
  logic [3:0]      make, brk, press, held_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic            rep_fire;
  // pending/serve vectors are {grav,rotate,down,right,left}
  logic [4:0]      pend_q, pend_nxt, set, clr;
  logic [4:0]      srv_q, srv_nxt, pick_srv;
  logic [2:0]      op_nxt, pick_op;
  logic            valid_nxt, miss_nxt;

  always_comb begin
    rx_nxt = rx_q;
    make   = 4'b0000;
    brk    = 4'b0000;
    if (ps2_key_pressed) begin
      case (rx_q)
        RX_IDLE: begin
          if (ps2_key_data == B_BRK)
            rx_nxt = RX_BRK;
          else if (ps2_key_data == B_EXT)
            rx_nxt = RX_EXT;
          else
            make = map_std(ps2_key_data);
        end
        RX_BRK: begin
          brk    = map_std(ps2_key_data);
          rx_nxt = RX_IDLE;
        end
        RX_EXT: begin
          if (ps2_key_data == B_BRK) begin
            rx_nxt = RX_EXTBRK;
          end else begin
            make   = map_ext(ps2_key_data);
            rx_nxt = RX_IDLE;
          end
        end
        RX_EXTBRK: begin
          brk    = map_ext(ps2_key_data);
          rx_nxt = RX_IDLE;
        end
        default: rx_nxt = RX_IDLE;
      endcase
    end
  end

  // typematic re-makes of a held key produce no new press
  assign press    = make & ~held;
  assign held_nxt = (held | make) & ~brk;

  always_comb begin
    cnt_nxt  = cnt_q;
    rep_fire = 1'b0;
    if (!enable || held_nxt[2:0] == 3'b000) begin
      cnt_nxt = '0;
    end else if (held_nxt[2:0] != held[2:0]) begin
      cnt_nxt = C_DLY;
    end else if (cnt_q != '0) begin
      if (cnt_q == C_ONE) begin
        rep_fire = 1'b1;
        cnt_nxt  = C_RAT;
      end else begin
        cnt_nxt = cnt_q - C_ONE;
      end
    end
  end

  always_comb begin
    set = {tick, press};
    if (rep_fire)
      set = set | {2'b00, held[2:0]};
  end

  // soft drop merges into a pending gravity step
  always_comb begin
    pick_op  = OP_GRAV;
    pick_srv = 5'b10000;
    if (pend_q[3]) begin
      pick_op  = OP_ROT;
      pick_srv = 5'b01000;
    end else if (pend_q[0]) begin
      pick_op  = OP_LEFT;
      pick_srv = 5'b00001;
    end else if (pend_q[1]) begin
      pick_op  = OP_RGHT;
      pick_srv = 5'b00010;
    end else if (pend_q[2] && pend_q[4]) begin
      pick_op  = OP_GRAV;
      pick_srv = 5'b10100;
    end else if (pend_q[2]) begin
      pick_op  = OP_DROP;
      pick_srv = 5'b00100;
    end
  end

  always_comb begin
    a_nxt     = a_q;
    valid_nxt = cmd_valid;
    op_nxt    = cmd_op;
    srv_nxt   = srv_q;
    clr       = 5'b00000;
    case (a_q)
      A_IDLE: begin
        if (enable && pend_q != 5'b00000) begin
          a_nxt     = A_OFFER;
          valid_nxt = 1'b1;
          op_nxt    = pick_op;
          srv_nxt   = pick_srv;
        end
      end
      A_OFFER: begin
        if (!enable || cmd_ready) begin
          clr       = cmd_ready ? srv_q : 5'b00000;
          a_nxt     = A_IDLE;
          valid_nxt = 1'b0;
          op_nxt    = OP_NONE;
          srv_nxt   = 5'b00000;
        end
      end
      default: begin
        a_nxt     = A_IDLE;
        valid_nxt = 1'b0;
        op_nxt    = OP_NONE;
        srv_nxt   = 5'b00000;
      end
    endcase
  end

  // new events win over the clear of the command just served
  assign pend_nxt = enable ? ((pend_q & ~clr) | set) : 5'b00000;
  assign miss_nxt = enable && tick && pend_q[4] && !clr[4];

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      rx_q         <= RX_IDLE;
      a_q          <= A_IDLE;
      held         <= 4'b0000;
      cnt_q        <= '0;
      pend_q       <= 5'b00000;
      srv_q        <= 5'b00000;
      cmd_valid    <= 1'b0;
      cmd_op       <= OP_NONE;
      gravity_miss <= 1'b0;
    end else begin
      rx_q         <= rx_nxt;
      a_q          <= a_nxt;
      held         <= held_nxt;
      cnt_q        <= cnt_nxt;
      pend_q       <= pend_nxt;
      srv_q        <= srv_nxt;
      cmd_valid    <= valid_nxt;
      cmd_op       <= op_nxt;
      gravity_miss <= miss_nxt;
    end
  end

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Scoreboard bench for tetris_move_scheduler.
// Short repeat timings; arrow-key expectations follow ARROW_KEYS_EN.
module tb_tetris_move_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       ps2_key_pressed = 1'b0;
  logic       tick = 1'b0;
  logic       enable = 1'b1;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [3:0] held;
  logic       gravity_miss;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  tetris_move_scheduler #(
    .CNT_W(8),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Resetn(Resetn),
    .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .tick(tick),
    .enable(enable),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .held(held),
    .gravity_miss(gravity_miss)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    step();
    ps2_key_pressed = 1'b0;
  endtask

  always @(negedge CLOCK_50) begin
    if (Resetn && enable && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0)
        chk("sb_extra", {29'd0, cmd_op}, 32'd0);
      else
        chk("sb_op", {29'd0, cmd_op}, {29'd0, exp_q.pop_front()});
    end
  end

  initial begin
    logic exp_v;
    repeat (3) step();
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_op", {29'd0, cmd_op}, 32'd0);
    chk("rst_held", {28'd0, held}, 32'd0);
    chk("rst_miss", {31'd0, gravity_miss}, 32'd0);
    Resetn = 1'b1;
    step();

    // single left press, latency 2
    cmd_ready = 1'b0;
    exp_q.push_back(3'd1);
    send(8'h1C);
    chk("lat_n1", {31'd0, cmd_valid}, 32'd0);
    step();
    chk("lat_valid", {31'd0, cmd_valid}, 32'd1);
    chk("lat_op", {29'd0, cmd_op}, 32'd1);
    chk("held_left", {28'd0, held}, 32'd1);
    cmd_ready = 1'b1;
    step();
    chk("xfer_drop", {31'd0, cmd_valid}, 32'd0);
    chk("xfer_op0", {29'd0, cmd_op}, 32'd0);
    send(8'hF0);
    send(8'h1C);
    chk("brk_left", {28'd0, held}, 32'd0);

    // rotate then right, one idle cycle apart
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd2);
    send(8'h1D);
    send(8'h23);
    chk("rot_valid", {31'd0, cmd_valid}, 32'd1);
    chk("rot_op", {29'd0, cmd_op}, 32'd4);
    step();
    chk("gap_idle", {31'd0, cmd_valid}, 32'd0);
    step();
    chk("rgt_valid", {31'd0, cmd_valid}, 32'd1);
    chk("rgt_op", {29'd0, cmd_op}, 32'd2);
    step();
    send(8'hF0);
    send(8'h1D);
    send(8'hF0);
    send(8'h23);
    chk("brk_both", {28'd0, held}, 32'd0);

    // held down key auto-repeat
    repeat (4) exp_q.push_back(3'd3);
    send(8'h1B);
    for (int k = 1; k <= 22; k++) begin
      ps2_key_pressed = (k >= 21);
      ps2_key_data    = (k == 21) ? 8'hF0 : 8'h1B;
      step();
      exp_v = (k == 1) || (k == 11) || (k == 15) || (k == 19);
      chk($sformatf("rep_k%0d", k), {31'd0, cmd_valid}, {31'd0, exp_v});
    end
    ps2_key_pressed = 1'b0;
    chk("rep_held", {28'd0, held}, 32'd0);
    step();

    // soft drop merged into gravity, then a missed tick
    cmd_ready = 1'b0;
    exp_q.push_back(3'd5);
    tick = 1'b1;
    send(8'h1B);
    tick = 1'b0;
    step();
    chk("mrg_valid", {31'd0, cmd_valid}, 32'd1);
    chk("mrg_op", {29'd0, cmd_op}, 32'd5);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("miss_hi", {31'd0, gravity_miss}, 32'd1);
    step();
    chk("miss_lo", {31'd0, gravity_miss}, 32'd0);
    cmd_ready = 1'b1;
    step();
    step();
    chk("mrg_empty", {31'd0, cmd_valid}, 32'd0);
    send(8'hF0);
    send(8'h1B);
    chk("mrg_empty2", {31'd0, cmd_valid}, 32'd0);

    // enable low aborts offer and flushes pending
    cmd_ready = 1'b0;
    send(8'h1C);
    send(8'h23);
    chk("en_valid", {31'd0, cmd_valid}, 32'd1);
    chk("en_op", {29'd0, cmd_op}, 32'd1);
    enable = 1'b0;
    step();
    chk("en_drop", {31'd0, cmd_valid}, 32'd0);
    step();
    chk("en_held", {28'd0, held}, 32'd3);
    enable = 1'b1;
    cmd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("en_flush%0d", k), {31'd0, cmd_valid}, 32'd0);
    end
    send(8'hF0);
    send(8'h1C);
    send(8'hF0);
    send(8'h23);
    step();

    // extended left arrow
`ifdef ARROW_KEYS_EN
    exp_q.push_back(3'd1);
    send(8'hE0);
    send(8'h6B);
    step();
    chk("arr_valid", {31'd0, cmd_valid}, 32'd1);
    chk("arr_op", {29'd0, cmd_op}, 32'd1);
    chk("arr_held", {28'd0, held}, 32'd1);
`else
    send(8'hE0);
    send(8'h6B);
    step();
    chk("arr_valid", {31'd0, cmd_valid}, 32'd0);
    chk("arr_held", {28'd0, held}, 32'd0);
`endif
    step();
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("arr_brk", {28'd0, held}, 32'd0);
    step();

    // reset during an offer
    cmd_ready = 1'b0;
    send(8'h23);
    step();
    chk("rr_valid", {31'd0, cmd_valid}, 32'd1);
    Resetn = 1'b0;
    step();
    chk("rr_vdrop", {31'd0, cmd_valid}, 32'd0);
    chk("rr_op", {29'd0, cmd_op}, 32'd0);
    chk("rr_held", {28'd0, held}, 32'd0);
    Resetn = 1'b1;
    cmd_ready = 1'b1;
    repeat (3) step();
    chk("rr_idle", {31'd0, cmd_valid}, 32'd0);

    chk("sb_left", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
